// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-ALU block: widths, opcodes, sequencer states.
package uart_alu_pkg;

   localparam int         NB_DATA_DEF  = 8;
   localparam int         NB_OP_DEF    = 6;
   localparam logic [7:0] ERR_CODE_DEF = 8'hFF;

   localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
   localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
   localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
   localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
   localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
   localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
   localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
   localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

   typedef enum logic [2:0] {
      ST_GET_A,
      ST_GET_B,
      ST_GET_OP,
      ST_EXEC,
      ST_SEND,
      ST_WAIT_TX
   } state_t;

   function automatic logic is_valid_op(input logic [NB_OP_DEF-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: counts idle cycles while enabled, flags the last allowed cycle.
module frame_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int NB_TIMEOUT     = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   logic [NB_TIMEOUT-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + 1'b1;
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame controller: gathers A, B, opcode from rx, latches the ALU result and
// launches one tx byte, with opcode check and inter-byte timeout.
module uart_alu_sequencer
   import uart_alu_pkg::*;
#(
   parameter int                 NB_DATA        = NB_DATA_DEF,
   parameter int                 NB_OP          = NB_OP_DEF,
   parameter int                 TIMEOUT_CYCLES = 1000000,
   parameter int                 NB_TIMEOUT     = 20,
   parameter logic [NB_DATA-1:0] ERR_CODE       = NB_DATA'(ERR_CODE_DEF)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx_done_tick,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_tx_done_tick,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_operation,
   output logic               o_busy,
   output logic               o_error
);

   state_t state;
   logic   in_frame;
   logic   expired;

   // Only the gaps inside a frame are timed; a byte restarts the window.
   assign in_frame = (state == ST_GET_B) || (state == ST_GET_OP);

   frame_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .NB_TIMEOUT     (NB_TIMEOUT)
   ) u_timeout (
      .clock   (i_clock),
      .reset   (i_reset),
      .clear   (i_rx_done_tick || !in_frame),
      .enable  (in_frame),
      .expired (expired)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= ST_GET_A;
         o_tx_start  <= 1'b0;
         o_tx_data   <= '0;
         o_data_a    <= '0;
         o_data_b    <= '0;
         o_operation <= '0;
         o_busy      <= 1'b0;
         o_error     <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         case (state)
            ST_GET_A: if (i_rx_done_tick) begin
               o_data_a <= i_rx_data;
               o_error  <= 1'b0;
               o_busy   <= 1'b1;
               state    <= ST_GET_B;
            end
            // A byte arriving on the expiry cycle wins over the timeout.
            ST_GET_B: if (i_rx_done_tick) begin
               o_data_b <= i_rx_data;
               state    <= ST_GET_OP;
            end else if (expired) begin
               o_error <= 1'b1;
               o_busy  <= 1'b0;
               state   <= ST_GET_A;
            end
            ST_GET_OP: if (i_rx_done_tick) begin
               o_operation <= i_rx_data[NB_OP-1:0];
               state       <= ST_EXEC;
            end else if (expired) begin
               o_error <= 1'b1;
               o_busy  <= 1'b0;
               state   <= ST_GET_A;
            end
            ST_EXEC: begin
               if (is_valid_op(NB_OP_DEF'(o_operation))) begin
                  o_tx_data <= i_alu_result;
               end else begin
                  o_tx_data <= ERR_CODE;
                  o_error   <= 1'b1;
               end
               o_tx_start <= 1'b1;
               state      <= ST_SEND;
            end
            ST_SEND: state <= ST_WAIT_TX;
            ST_WAIT_TX: if (i_tx_done_tick) begin
               o_busy <= 1'b0;
               state  <= ST_GET_A;
            end
            default: begin
               o_busy <= 1'b0;
               state  <= ST_GET_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Randomized scoreboard bench for uart_alu_sequencer with a stand-in ALU and tx responder.
module tb_uart_alu_sequencer;

   localparam int TO = 16;

   typedef struct {
      logic [7:0] tx;
      logic       err;
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_rx_done_tick = 1'b0;
   logic [7:0] i_rx_data = '0;
   logic [7:0] i_alu_result;
   logic       i_tx_done_tick = 1'b0;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic [7:0] o_data_a;
   logic [7:0] o_data_b;
   logic [5:0] o_operation;
   logic       o_busy;
   logic       o_error;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   tx_delay = 3;
   logic early_done = 1'b0;
   exp_t sb[$];
   exp_t me;

   logic [5:0] ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b100110, 6'b100111, 6'b000011, 6'b000010};

   always #5 clk = ~clk;

   uart_alu_sequencer #(.TIMEOUT_CYCLES(TO), .NB_TIMEOUT(20)) dut (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_rx_done_tick (i_rx_done_tick),
      .i_rx_data      (i_rx_data),
      .i_alu_result   (i_alu_result),
      .i_tx_done_tick (i_tx_done_tick),
      .o_tx_start     (o_tx_start),
      .o_tx_data      (o_tx_data),
      .o_data_a       (o_data_a),
      .o_data_b       (o_data_b),
      .o_operation    (o_operation),
      .o_busy         (o_busy),
      .o_error        (o_error)
   );

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
      case (op)
         6'b100000: return a + b;
         6'b100010: return a - b;
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b100110: return a ^ b;
         6'b100111: return ~(a | b);
         6'b000011: return 8'($signed(a) >>> b);
         6'b000010: return a >> b;
         default:   return a ^ b ^ 8'h5A;
      endcase
   endfunction

   function automatic logic valid_ref(input logic [5:0] op);
      for (int i = 0; i < 8; i++) if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   assign i_alu_result = alu_fn(o_data_a, o_data_b, o_operation);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every start pulse must match the oldest pending frame.
   always @(negedge clk) begin
      if (o_tx_start) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_tx_start: got a start pulse, required none (t=%0t)", $time);
         end else begin
            me = sb.pop_front();
            chk("tx_data", 32'(o_tx_data), 32'(me.tx));
            chk("error_at_tx", 32'(o_error), 32'(me.err));
            chk("data_a", 32'(o_data_a), 32'(me.a));
            chk("data_b", 32'(o_data_b), 32'(me.b));
            chk("operation", 32'(o_operation), 32'(me.op));
            chk("tx_latency", 32'(cyc), 32'(me.cyc));
         end
      end
      cyc++;
   end

   // Transmitter stand-in, optionally with a spurious done while in SEND.
   initial begin
      forever begin
         @(negedge clk);
         if (o_tx_start) begin
            if (early_done) begin
               i_tx_done_tick = 1'b1;
               @(posedge clk); #1 i_tx_done_tick = 1'b0;
               @(negedge clk);
               chk("busy_after_send_done", 32'(o_busy), 32'd1);
            end
            repeat (tx_delay) @(posedge clk);
            #1 i_tx_done_tick = 1'b1;
            @(posedge clk); #1 i_tx_done_tick = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input int gap, output int t);
      repeat (gap) @(posedge clk);
      @(posedge clk); #1;
      i_rx_data = d;
      i_rx_done_tick = 1'b1;
      @(posedge clk);
      t = cyc;
      #1;
      i_rx_done_tick = 1'b0;
      i_rx_data = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (o_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", 32'(o_busy), 32'd0);
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input int g1, input int g2);
      exp_t e;
      int t;
      wait_idle();
      send_byte(a, int'($urandom_range(0, 3)), t);
      @(negedge clk);
      chk("err_clear_on_a", 32'(o_error), 32'd0);
      chk("busy_after_a", 32'(o_busy), 32'd1);
      send_byte(b, g1, t);
      send_byte(opb, g2, t);
      e.a   = a;
      e.b   = b;
      e.op  = opb[5:0];
      e.err = !valid_ref(opb[5:0]);
      e.tx  = e.err ? 8'hFF : alu_fn(a, b, opb[5:0]);
      e.cyc = t + 1;
      sb.push_back(e);
   endtask

   task automatic check_zero(input string tag);
      @(negedge clk);
      chk({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
      chk({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
      chk({tag, "_data_a"}, 32'(o_data_a), 32'd0);
      chk({tag, "_data_b"}, 32'(o_data_b), 32'd0);
      chk({tag, "_operation"}, 32'(o_operation), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_error"}, 32'(o_error), 32'd0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 i_reset = 1'b1;
      @(posedge clk); #1 i_reset = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic [7:0] a, b, opb;
      logic [5:0] op;

      repeat (3) @(posedge clk);
      #1 i_reset = 1'b0;
      check_zero("reset");

      // Directed ADD, then invalid opcode, then a frame that must clear the error.
      run_frame(8'h05, 8'h03, 8'h20, 1, 1);
      drain();
      run_frame(8'h0A, 8'h01, 8'h3F, 0, 2);
      drain();
      @(negedge clk);
      chk("error_sticky", 32'(o_error), 32'd1);
      run_frame(8'h40, 8'h04, 8'hA2, 0, 0);

      // Partial frame then silence: leaves on exactly the last allowed cycle.
      wait_idle();
      send_byte(8'h11, 0, t);
      send_byte(8'h22, 0, t);
      repeat (TO - 1) @(posedge clk);
      @(negedge clk);
      chk("to_busy_before", 32'(o_busy), 32'd1);
      chk("to_error_before", 32'(o_error), 32'd0);
      @(negedge clk);
      chk("to_busy_after", 32'(o_busy), 32'd0);
      chk("to_error_after", 32'(o_error), 32'd1);
      chk("to_data_a_kept", 32'(o_data_a), 32'h11);
      repeat (5) @(negedge clk);
      run_frame(8'h33, 8'h44, 8'h26, 2, 3);
      drain();

      // Bytes landing exactly on the expiry cycle are still taken.
      run_frame(8'h81, 8'h02, 8'h03, TO - 2, TO - 2);
      drain();

      // Extra rx ticks while the transmitter is busy.
      tx_delay = 12;
      early_done = 1'b0;
      run_frame(8'h5C, 8'h13, 8'h24, 0, 0);
      send_byte(8'hE1, 0, t);
      send_byte(8'hE2, 0, t);
      send_byte(8'hE3, 0, t);
      wait_idle();
      chk("extra_data_a", 32'(o_data_a), 32'h5C);
      chk("extra_data_b", 32'(o_data_b), 32'h13);
      drain();

      // Reset mid-frame (GET_OP).
      tx_delay = 3;
      wait_idle();
      send_byte(8'h77, 0, t);
      send_byte(8'h66, 0, t);
      pulse_reset();
      check_zero("rst_getop");
      repeat (TO + 4) @(posedge clk);
      @(negedge clk);
      chk("rst_getop_idle", 32'(o_busy), 32'd0);

      // Reset while waiting on the transmitter.
      tx_delay = 40;
      run_frame(8'h09, 8'h07, 8'h22, 0, 0);
      drain();
      repeat (2) @(posedge clk);
      pulse_reset();
      check_zero("rst_waittx");
      repeat (60) @(posedge clk);
      @(negedge clk);
      chk("rst_waittx_idle", 32'(o_busy), 32'd0);

      // Randomized frames.
      for (int i = 0; i < 25; i++) begin
         tx_delay   = int'($urandom_range(1, 6));
         early_done = 1'($urandom_range(0, 1));
         a = 8'($urandom);
         b = 8'($urandom);
         if ($urandom_range(0, 3) != 0) op = ops[$urandom_range(0, 7)];
         else op = 6'($urandom);
         opb = {2'($urandom), op};
         run_frame(a, b, opb, int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
      end
      wait_idle();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
